// File: rtl/toggle_req_pkg.sv
// Shared FSM encoding and default timing constants for the toggle request front-end.
package toggle_req_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int DEFAULT_REPEAT_DELAY    = 64;
    localparam int DEFAULT_REPEAT_PERIOD   = 32;

endpackage

// File: rtl/toggle_req_debounce_sync_ff.sv
// Multi-flop level synchronizer for the asynchronous button input.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/toggle_req_debounce.sv
// Debounces a raw button into a one-cycle toggle request and a clean level.
// Optional auto-repeat while held: define TOGGLE_REQ_AUTOREPEAT_EN.
module toggle_req_debounce
    import toggle_req_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic t_out,
    output logic btn_level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be in 2..4");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_rpt
        $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 2");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             t_out_q, t_out_d;
    logic             btn_level_q, btn_level_d;
    logic             sync_out;
    logic             cnt_done;
    logic             rpt_fire;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (sync_out)
    );

    assign cnt_done = (cnt_q == CNT_W'(DEBOUNCE_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            t_out_q     <= 1'b0;
            btn_level_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            t_out_q     <= t_out_d;
            btn_level_q <= btn_level_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sync_out) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync_out) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!sync_out) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync_out) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef TOGGLE_REQ_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d, rpt_target;
    logic             rpt_armed_q, rpt_armed_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_armed_q <= rpt_armed_d;
        end
    end

    // Counts only while staying in HELD; frozen through a release bounce, cleared otherwise.
    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_armed_d = rpt_armed_q;
        rpt_fire    = 1'b0;
        rpt_target  = rpt_armed_q ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY);
        if (state_q == HELD && state_d == HELD) begin
            if (rpt_cnt_q + RPT_W'(1) == rpt_target) begin
                rpt_fire    = 1'b1;
                rpt_cnt_d   = '0;
                rpt_armed_d = 1'b1;
            end else begin
                rpt_cnt_d   = rpt_cnt_q + RPT_W'(1);
            end
        end else if (state_d == HELD || state_d == RELEASE_WAIT) begin
            rpt_cnt_d   = rpt_cnt_q;
        end else begin
            rpt_cnt_d   = '0;
            rpt_armed_d = 1'b0;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_comb begin
        t_out_d     = ((state_q == PRESS_WAIT) && sync_out && cnt_done) || rpt_fire;
        btn_level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    end

    assign t_out     = t_out_q;
    assign btn_level = btn_level_q;

endmodule

// File: tb/tb_toggle_req_debounce.sv
// Directed bench for toggle_req_debounce (SYNC_STAGES=2, DEBOUNCE_CYCLES=4) with a T flip-flop model.
module tb_toggle_req_debounce;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b0;
    logic t_out;
    logic btn_level;
    logic q;
    int   checks = 0;
    int   failures = 0;

    toggle_req_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .t_out     (t_out),
        .btn_level (btn_level)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (rst) q <= 1'b0;
        else if (t_out) q <= ~q;
    end

    // Runs n edges, sampling 1 time unit after each; edges are numbered from 1.
    task automatic observe(input int n, output int pulses, output int first_pulse,
                           output int lvl_edge, output int consec);
        logic prev_lvl, prev_t;
        pulses = 0; first_pulse = -1; lvl_edge = -1; consec = 0;
        prev_lvl = btn_level; prev_t = t_out;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            if (t_out === 1'b1) begin
                pulses++;
                if (first_pulse < 0) first_pulse = k;
                if (prev_t === 1'b1) consec++;
            end
            if (btn_level !== prev_lvl && lvl_edge < 0) lvl_edge = k;
            prev_lvl = btn_level; prev_t = t_out;
        end
    endtask

    task automatic test_reset();
        int p, f, l, c;
        rst = 1'b1; btn_in = 1'b1;
        observe(3, p, f, l, c);
        checks++; if (t_out !== 1'b0) begin failures++; $display("FAIL reset_t_out got=%b exp=0", t_out); end
        checks++; if (btn_level !== 1'b0) begin failures++; $display("FAIL reset_btn_level got=%b exp=0", btn_level); end
        checks++; if (p !== 0) begin failures++; $display("FAIL reset_pulses got=%0d exp=0", p); end
        btn_in = 1'b0; rst = 1'b0;
        observe(6, p, f, l, c);
        checks++; if (p !== 0 || btn_level !== 1'b0) begin failures++; $display("FAIL reset_idle got pulses=%0d lvl=%b exp 0/0", p, btn_level); end
    endtask

    task automatic test_clean_press();
        int p, f, l, c;
        btn_in = 1'b1;
        observe(20, p, f, l, c);
        checks++; if (p !== 1) begin failures++; $display("FAIL press_pulses got=%0d exp=1", p); end
        checks++; if (f !== 7) begin failures++; $display("FAIL press_pulse_edge got=%0d exp=7", f); end
        checks++; if (l !== 7) begin failures++; $display("FAIL press_level_edge got=%0d exp=7", l); end
        checks++; if (c !== 0) begin failures++; $display("FAIL press_consecutive got=%0d exp=0", c); end
        checks++; if (btn_level !== 1'b1) begin failures++; $display("FAIL press_level_held got=%b exp=1", btn_level); end
    endtask

    task automatic test_release();
        int p, f, l, c;
        btn_in = 1'b0;
        observe(10, p, f, l, c);
        checks++; if (p !== 0) begin failures++; $display("FAIL release_pulses got=%0d exp=0", p); end
        checks++; if (l !== 7) begin failures++; $display("FAIL release_level_edge got=%0d exp=7", l); end
        checks++; if (btn_level !== 1'b0) begin failures++; $display("FAIL release_level got=%b exp=0", btn_level); end
    endtask

    task automatic test_release_glitch();
        int p, f, l, c, p2, l2;
        btn_in = 1'b1;
        observe(12, p, f, l, c);
        checks++; if (f !== 7) begin failures++; $display("FAIL glitch_press_edge got=%0d exp=7", f); end
        btn_in = 1'b0;
        observe(3, p, f, l, c);
        btn_in = 1'b1;
        observe(15, p2, f, l2, c);
        checks++; if (p + p2 !== 0) begin failures++; $display("FAIL glitch_pulses got=%0d exp=0", p + p2); end
        checks++; if (l !== -1 || l2 !== -1 || btn_level !== 1'b1) begin failures++; $display("FAIL glitch_level got chg=%0d/%0d lvl=%b exp -1/-1/1", l, l2, btn_level); end
        btn_in = 1'b0;
        observe(12, p, f, l, c);
        checks++; if (btn_level !== 1'b0) begin failures++; $display("FAIL glitch_release got=%b exp=0", btn_level); end
    endtask

    task automatic test_debounce_boundary();
        int p, f, l, c, p2, l2;
        btn_in = 1'b1; observe(4, p, f, l, c);
        btn_in = 1'b0; observe(12, p2, f, l2, c);
        checks++; if (p + p2 !== 0 || l !== -1 || l2 !== -1) begin failures++; $display("FAIL bound_short got pulses=%0d chg=%0d/%0d exp 0/-1/-1", p + p2, l, l2); end
        btn_in = 1'b1; observe(5, p, f, l, c);
        checks++; if (p !== 0) begin failures++; $display("FAIL bound_long_early got=%0d exp=0", p); end
        btn_in = 1'b0; observe(14, p, f, l, c);
        checks++; if (p !== 1 || f !== 2) begin failures++; $display("FAIL bound_long got pulses=%0d edge=%0d exp 1/2", p, f); end
        checks++; if (l !== 2 || btn_level !== 1'b0) begin failures++; $display("FAIL bound_long_level got chg=%0d lvl=%b exp 2/0", l, btn_level); end
    endtask

    task automatic test_bounce();
        int p, f, l, c, tot, chg;
        tot = 0; chg = 0;
        for (int i = 0; i < 4; i++) begin
            btn_in = (i % 2 == 0) ? 1'b1 : 1'b0;
            observe(2, p, f, l, c);
            tot += p;
            if (l >= 0) chg++;
        end
        checks++; if (tot !== 0 || chg !== 0) begin failures++; $display("FAIL bounce_quiet got pulses=%0d chg=%0d exp 0/0", tot, chg); end
        btn_in = 1'b1;
        observe(15, p, f, l, c);
        checks++; if (p !== 1 || f !== 7) begin failures++; $display("FAIL bounce_accept got pulses=%0d edge=%0d exp 1/7", p, f); end
        btn_in = 1'b0;
        observe(12, p, f, l, c);
        checks++; if (p !== 0 || btn_level !== 1'b0) begin failures++; $display("FAIL bounce_release got pulses=%0d lvl=%b exp 0/0", p, btn_level); end
    endtask

    task automatic test_reset_mid_press();
        int p, f, l, c, p2;
        btn_in = 1'b1;
        observe(4, p, f, l, c);
        rst = 1'b1;
        observe(1, p2, f, l, c);
        checks++; if (p + p2 !== 0 || t_out !== 1'b0 || btn_level !== 1'b0) begin failures++; $display("FAIL midrst_window got pulses=%0d t=%b lvl=%b exp 0/0/0", p + p2, t_out, btn_level); end
        rst = 1'b0;
        observe(15, p, f, l, c);
        checks++; if (p !== 1 || f !== 7) begin failures++; $display("FAIL midrst_repress got pulses=%0d edge=%0d exp 1/7", p, f); end
        btn_in = 1'b0;
        observe(12, p, f, l, c);
    endtask

    task automatic test_tff_chain();
        int p, f, l, c;
        logic exp_q [3];
        exp_q[0] = 1'b1; exp_q[1] = 1'b0; exp_q[2] = 1'b1;
        rst = 1'b1; btn_in = 1'b0;
        observe(2, p, f, l, c);
        rst = 1'b0;
        checks++; if (q !== 1'b0) begin failures++; $display("FAIL tff_reset got=%b exp=0", q); end
        for (int i = 0; i < 3; i++) begin
            btn_in = 1'b1; observe(10, p, f, l, c);
            btn_in = 1'b0; observe(10, p, f, l, c);
            checks++; if (q !== exp_q[i]) begin failures++; $display("FAIL tff_press%0d got=%b exp=%b", i, q, exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release();
        test_release_glitch();
        test_debounce_boundary();
        test_bounce();
        test_reset_mid_press();
        test_tff_chain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
